// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample source: mode encodings, LFSR constants
// and the per-sample pattern/LFSR helper functions.
package fir_pkg;

  localparam int FIR_W = 3;

  typedef enum logic [1:0] {
    MODE_IMPULSE = 2'd0,
    MODE_SQUARE  = 2'd1,
    MODE_ALT     = 2'd2,
    MODE_LFSR    = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Galois right-shift step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Sample value for one strobe; p_high is the phase MSB (second half of the period).
  function automatic logic [FIR_W-1:0] fir_pattern(
    input logic [1:0]       mode,
    input logic [FIR_W-1:0] amp,
    input logic             p_zero,
    input logic             p_high,
    input logic             odd,
    input logic [15:0]      lfsr
  );
    logic [FIR_W-1:0] v;
    case (mode)
      MODE_IMPULSE: v = p_zero ? amp : {FIR_W{1'b0}};
      MODE_SQUARE:  v = p_high ? amp : {FIR_W{1'b0}};
      MODE_ALT:     v = odd ? FIR_W'(~amp + FIR_W'(1)) : amp;
      MODE_LFSR:    v = lfsr[FIR_W-1:0];
      default:      v = {FIR_W{1'b0}};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fir_lfsr16.sv
// 16-bit Galois LFSR with synchronous reseed (reset or load) and single-step advance.
module fir_lfsr16
  import fir_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_adv,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // LFSR state register: reseed has priority over advance.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_state <= LFSR_SEED;
    end else if (i_adv) begin
      r_state <= lfsr_next(r_state);
    end else begin
      r_state <= r_state;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/fir_sample_source.sv
// Sample strobe generator and pattern source feeding the FIR input.
// All outputs are registered; the start edge already produces strobe 0.
module fir_sample_source
  import fir_pkg::*;
#(
  parameter int DIV    = 20,
  parameter int PERIOD = 64,
  parameter int CNT_W  = 16
) (
  input  logic             iClk_12MHz,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iStop,
  input  logic [1:0]       iMode,
  input  logic [FIR_W-1:0] iAmp,
  input  logic [CNT_W-1:0] iNumSamples,
  output logic             oEnSample_600kHz,
  output logic [FIR_W-1:0] oFirIn,
  output logic             oBusy,
  output logic             oDone
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PH_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [PH_W-1:0]  r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_mode;
  logic [FIR_W-1:0] r_amp;
  logic [CNT_W-1:0] r_num;
  logic             r_strobe, w_strobe_nxt;
  logic [FIR_W-1:0] r_fir, w_fir_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_latch;
  logic             w_div_wrap;
  logic [15:0]      w_lfsr;

  fir_lfsr16 u_lfsr (
    .i_clk   (iClk_12MHz),
    .i_rst   (iRst),
    .i_load  (w_latch),
    .i_adv   (r_strobe),
    .o_state (w_lfsr)
  );

  assign w_div_wrap = (r_div == DIV_W'(DIV - 1));

  // Next-state and next-output logic; r_cnt/r_phase always describe the next sample to emit.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_phase_nxt  = r_phase;
    w_cnt_nxt    = r_cnt;
    w_strobe_nxt = 1'b0;
    w_fir_nxt    = r_fir;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iStart && !iStop) begin
          w_state_nxt  = ST_RUN;
          w_latch      = 1'b1;
          w_div_nxt    = {DIV_W{1'b0}};
          w_phase_nxt  = PH_W'(1);
          w_cnt_nxt    = CNT_W'(1);
          w_strobe_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          w_fir_nxt    = fir_pattern(iMode, iAmp, 1'b1, 1'b0, 1'b0, LFSR_SEED);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (iStop) begin
          w_state_nxt = ST_IDLE;
          w_fir_nxt   = {FIR_W{1'b0}};
        end else if (w_div_wrap && (r_num != {CNT_W{1'b0}}) && (r_cnt == r_num)) begin
          w_state_nxt = ST_IDLE;
          w_fir_nxt   = {FIR_W{1'b0}};
          w_done_nxt  = 1'b1;
        end else begin
          w_busy_nxt = 1'b1;
          if (w_div_wrap) begin
            w_div_nxt    = {DIV_W{1'b0}};
            w_strobe_nxt = 1'b1;
            w_fir_nxt    = fir_pattern(r_mode, r_amp, (r_phase == {PH_W{1'b0}}),
                                       r_phase[PH_W-1], r_cnt[0], w_lfsr);
            w_phase_nxt  = PH_W'(r_phase + PH_W'(1));
            w_cnt_nxt    = CNT_W'(r_cnt + CNT_W'(1));
          end else begin
            w_div_nxt = DIV_W'(r_div + DIV_W'(1));
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_fir_nxt   = {FIR_W{1'b0}};
      end
    endcase
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge iClk_12MHz) begin
    if (iRst) begin
      r_state  <= ST_IDLE;
      r_div    <= {DIV_W{1'b0}};
      r_phase  <= {PH_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_mode   <= 2'd0;
      r_amp    <= {FIR_W{1'b0}};
      r_num    <= {CNT_W{1'b0}};
      r_strobe <= 1'b0;
      r_fir    <= {FIR_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_phase  <= w_phase_nxt;
      r_cnt    <= w_cnt_nxt;
      r_strobe <= w_strobe_nxt;
      r_fir    <= w_fir_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      if (w_latch) begin
        r_mode <= iMode;
        r_amp  <= iAmp;
        r_num  <= iNumSamples;
      end else begin
        r_mode <= r_mode;
        r_amp  <= r_amp;
        r_num  <= r_num;
      end
    end
  end

  assign oEnSample_600kHz = r_strobe;
  assign oFirIn           = r_fir;
  assign oBusy            = r_busy;
  assign oDone            = r_done;

endmodule
